// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Purpose  : Memory-mapped down-counting timer with a maskable interrupt
//            request. The bridge decodes the base address, and this block
//            decodes only addr[3:2].
// Revision : 1.0  initial release
// ============================================================================
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PRESET = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_AUTO  = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic [1:0]  w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_auto;
    logic        w_unused;

    assign w_sel       = addr[3:2];
    assign w_wr_ctrl   = we && (w_sel == c_REG_CTRL);
    assign w_wr_preset = we && (w_sel == c_REG_PRESET);
    assign w_en        = r_ctrl[0];
    assign w_auto      = (r_ctrl[2:1] == c_MODE_AUTO);
    assign w_unused    = ^{addr[31:4], addr[1:0]};

    // The CPU write comes after the FSM, so it overrides the hardware EN clear in INT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!w_en) begin
                        r_state <= S_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count    <= 32'd0;
                        r_irq_flag <= 1'b1;
                        r_state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_auto) begin
                        r_irq_flag <= 1'b0;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_wr_ctrl) begin
                r_ctrl     <= din[3:0];
                r_irq_flag <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= din;
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (w_sel)
            c_REG_CTRL:   dout = {28'd0, r_ctrl};
            c_REG_PRESET: dout = r_preset;
            c_REG_COUNT:  dout = r_count;
            default:      dout = 32'd0;
        endcase
    end

    assign irq = r_ctrl[3] & r_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_counter
// Purpose  : Directed and randomized bench for timer_counter with a
//            timeline-style reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_counter u_dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model. m_phase: 0 idle, 1 loading, 2 counting, 3 expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    task automatic m_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [3:0] nc;
        logic       nf;
        nc = m_ctrl;
        nf = m_flag;
        if (m_phase == 0) begin
            if (m_ctrl[0]) m_phase = 1;
        end else if (m_phase == 1) begin
            m_count = m_preset;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (!m_ctrl[0]) m_phase = 0;
            else if (m_count > 1) m_count = m_count - 1;
            else begin m_count = 0; nf = 1'b1; m_phase = 3; end
        end else begin
            if (m_ctrl[2:1] == 2'd1) nf = 1'b0;
            else nc[0] = 1'b0;
            m_phase = 0;
        end
        if (w && a[3:2] == 2'd0) begin nc = d[3:0]; nf = 1'b0; end
        if (w && a[3:2] == 2'd1) m_preset = d;
        m_ctrl = nc;
        m_flag = nf;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, compare against the model, then advance both.
    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic ri);
        @(negedge clk);
        we = w; addr = a; din = d;
        #1;
        rd = dout;
        ri = irq;
        chk("dout_model", dout, m_read(a));
        chk("irq_model", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
        @(posedge clk);
        m_step(w, a, d);
    endtask

    logic [31:0] rd;
    logic        ri;
    int          rise_edge;
    int          rises[$];
    int          dbl_high;
    logic        prev;

    // Returns the edge index (relative to the last write edge e0) at which irq rose.
    task automatic edge_of_irq(input int bound, output int e);
        e = -1;
        for (int i = 1; i <= bound; i++) begin
            cyc(1'b0, 32'h8, 32'd0, rd, ri);
            if (ri && e < 0) begin e = i - 1; break; end
        end
    endtask

    task automatic stop_and_settle();
        cyc(1'b1, 32'h0, 32'h0, rd, ri);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = 32'd0; din = 32'd0;
        m_reset();
        #12;
        chk("reset_ctrl", dout, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Mode 0 one-shot with PRESET=4
        cyc(1'b1, 32'h4, 32'd4, rd, ri);
        cyc(1'b1, 32'h0, 32'h9, rd, ri);
        edge_of_irq(20, rise_edge);
        chk("mode0_irq_edge", rise_edge, 32'd6);
        cyc(1'b0, 32'h0, 32'd0, rd, ri);
        chk("mode0_ctrl_en_cleared", rd, 32'h8);
        chk("mode0_irq_held", {31'd0, ri}, 32'd1);

        // Acknowledge
        cyc(1'b1, 32'h0, 32'h8, rd, ri);
        cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("ack_irq_low", {31'd0, ri}, 32'd0);
        chk("ack_count_zero", rd, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("ack_no_count", rd, 32'd0);

        // Mode 1 auto-reload, PRESET=2 -> period 5
        cyc(1'b1, 32'h4, 32'd2, rd, ri);
        cyc(1'b1, 32'h0, 32'hB, rd, ri);
        rises.delete();
        dbl_high = 0;
        prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0, 32'h8, 32'd0, rd, ri);
            if (ri && !prev) rises.push_back(i - 1);
            if (ri && prev) dbl_high++;
            prev = ri;
        end
        chk("mode1_pulses", {31'd0, rises.size() >= 3}, 32'd1);
        if (rises.size() >= 3) begin
            chk("mode1_first", rises[0], 32'd4);
            chk("mode1_period_a", rises[1] - rises[0], 32'd5);
            chk("mode1_period_b", rises[2] - rises[1], 32'd5);
        end
        chk("mode1_one_cycle", dbl_high, 32'd0);
        stop_and_settle();

        // PRESET=0 fires at e3
        cyc(1'b1, 32'h4, 32'd0, rd, ri);
        cyc(1'b1, 32'h0, 32'h9, rd, ri);
        edge_of_irq(20, rise_edge);
        chk("preset0_irq_edge", rise_edge, 32'd3);
        stop_and_settle();

        // Max PRESET, no wrap; COUNT is read-only
        cyc(1'b1, 32'h4, 32'hFFFF_FFFF, rd, ri);
        cyc(1'b1, 32'h0, 32'h1, rd, ri);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("max_loaded", rd, 32'hFFFF_FFFF);
        cyc(1'b1, 32'h8, 32'h1234, rd, ri);
        chk("max_dec", rd, 32'hFFFF_FFFE);
        cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("count_write_ignored", rd, 32'hFFFF_FFFD);
        stop_and_settle();
        cyc(1'b1, 32'hC, 32'hFFFF_FFFF, rd, ri);
        cyc(1'b0, 32'hC, 32'd0, rd, ri);
        chk("reserved_read", rd, 32'd0);

        // CTRL write colliding with the hardware EN clear
        cyc(1'b1, 32'h4, 32'd3, rd, ri);
        cyc(1'b1, 32'h0, 32'h9, rd, ri);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
        cyc(1'b1, 32'h0, 32'h9, rd, ri);
        chk("collide_irq_before", {31'd0, ri}, 32'd1);
        cyc(1'b0, 32'h0, 32'd0, rd, ri);
        chk("collide_ctrl_wins", rd, 32'h9);
        chk("collide_flag_clr", {31'd0, ri}, 32'd0);
        cyc(1'b0, 32'h8, 32'd0, rd, ri);
        cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("collide_restart", rd, 32'd3);
        stop_and_settle();

        // IM=0: flag sets silently; a later IM=1 write clears it
        cyc(1'b1, 32'h4, 32'd1, rd, ri);
        cyc(1'b1, 32'h0, 32'h1, rd, ri);
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 32'h0, 32'd0, rd, ri);
            prev = prev | ri;
        end
        chk("mask_no_irq", {31'd0, prev}, 32'd0);
        cyc(1'b1, 32'h0, 32'h8, rd, ri);
        cyc(1'b0, 32'h0, 32'd0, rd, ri);
        chk("mask_late_im", {31'd0, ri}, 32'd0);

        // Asynchronous reset mid-count with COUNT=5
        cyc(1'b1, 32'h4, 32'd8, rd, ri);
        cyc(1'b1, 32'h0, 32'h9, rd, ri);
        for (int i = 0; i < 20 && rd != 32'd6; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("pre_reset_count", rd, 32'd6);
        @(negedge clk);
        we = 1'b0; addr = 32'h8;
        #1 chk("pre_reset_count5", dout, 32'd5);
        #1 reset = 1'b1;
        m_reset();
        #1 chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_count", dout, 32'd0);
        addr = 32'h0; #1 chk("rst_ctrl", dout, 32'd0);
        addr = 32'h4; #1 chk("rst_preset", dout, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h8, 32'd0, rd, ri);
        chk("rst_idle", rd, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int          op;
            logic [31:0] a;
            a  = $urandom;
            op = $urandom_range(0, 11);
            case (op)
                0, 1: cyc(1'b1, (a & ~32'hC), 32'($urandom_range(0, 15)), rd, ri);
                2:    cyc(1'b1, (a & ~32'hC) | 32'h4, 32'($urandom_range(0, 6)), rd, ri);
                3:    cyc(1'b1, (a & ~32'hC) | 32'h8, $urandom, rd, ri);
                4:    cyc(1'b1, a | 32'hC, $urandom, rd, ri);
                default: cyc(1'b0, a, $urandom, rd, ri);
            endcase
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                we = 1'b0;
                #2 reset = 1'b1;
                m_reset();
                @(posedge clk); #1 reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
